// File: rtl/btb_upd_arb.sv
// BTB write-port arbiter: buffered predecode writes vs. prioritised resolve writes with a starvation bound.
// Optional BTB_ARB_SQUASH_EN: resolve grants invalidate queued predecode entries with the same PC.
module btb_upd_arb #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     dec_vld_i,
  output logic                     dec_rdy_o,
  input  logic [63:0]              dec_pc_i,
  input  logic [2:0]               dec_pos_i,
  input  logic [1:0]               dec_typ_i,
  input  logic [63:0]              dec_tar_i,
  input  logic                     res_vld_i,
  output logic                     res_rdy_o,
  input  logic [63:0]              res_pc_i,
  input  logic [2:0]               res_pos_i,
  input  logic [1:0]               res_typ_i,
  input  logic [63:0]              res_tar_i,
  input  logic                     res_inv_i,
  input  logic                     flush_i,
  input  logic                     btb_stall_i,
  output logic                     btb_we_o,
  output logic                     btb_inv_o,
  output logic [63:0]              btb_pc_o,
  output logic [2:0]               btb_pos_o,
  output logic [1:0]               btb_typ_o,
  output logic [63:0]              btb_tar_o,
  output logic [$clog2(DEPTH):0]   qcnt_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [63:0]      pc_q  [DEPTH];
  logic [2:0]       pos_q [DEPTH];
  logic [1:0]       typ_q [DEPTH];
  logic [63:0]      tar_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d, kill;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [SW-1:0]    starve_q;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             empty, full, head_vld, head_squashed;
  logic             force_dec, res_grant, dec_grant, push, pop;

  assign wr_idx        = wr_ptr_q[IW-1:0];
  assign rd_idx        = rd_ptr_q[IW-1:0];
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign head_vld      = !empty && vld_q[rd_idx];
  assign head_squashed = !empty && !vld_q[rd_idx];
  assign qcnt_o        = wr_ptr_q - rd_ptr_q;

  assign force_dec = (starve_q == SW'(STARVE_MAX)) && head_vld;
  assign res_grant = rst_n_i && res_vld_i && !btb_stall_i && !force_dec;
  assign res_rdy_o = res_grant;
  assign dec_grant = head_vld && !btb_stall_i && !flush_i && (!res_vld_i || force_dec);
  assign dec_rdy_o = rst_n_i && !full;
  assign push      = dec_vld_i && dec_rdy_o && !flush_i;
  // Squashed heads drain without using the write port, independent of stall.
  assign pop       = dec_grant || head_squashed;

`ifdef BTB_ARB_SQUASH_EN
  always_comb begin
    kill = '0;
    if (res_grant) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (pc_q[i] == res_pc_i)) kill[i] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    kill = '0;
  end
`endif

  always_comb begin
    vld_d = vld_q & ~kill;
    if (pop)  vld_d[rd_idx] = 1'b0;
    if (push) vld_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_q[wr_idx]  <= dec_pc_i;
      pos_q[wr_idx] <= dec_pos_i;
      typ_q[wr_idx] <= dec_typ_i;
      tar_q[wr_idx] <= dec_tar_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
    end else if (flush_i || empty || dec_grant) begin
      starve_q <= '0;
    end else if (res_grant && head_vld && (starve_q != SW'(STARVE_MAX))) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btb_we_o  <= 1'b0;
      btb_inv_o <= 1'b0;
      btb_pc_o  <= '0;
      btb_pos_o <= '0;
      btb_typ_o <= '0;
      btb_tar_o <= '0;
    end else begin
      btb_we_o  <= res_grant || dec_grant;
      btb_inv_o <= res_grant && res_inv_i;
      if (res_grant) begin
        btb_pc_o  <= res_pc_i;
        btb_pos_o <= res_pos_i;
        btb_typ_o <= res_typ_i;
        btb_tar_o <= res_tar_i;
      end else if (dec_grant) begin
        btb_pc_o  <= pc_q[rd_idx];
        btb_pos_o <= pos_q[rd_idx];
        btb_typ_o <= typ_q[rd_idx];
        btb_tar_o <= tar_q[rd_idx];
      end
    end
  end

endmodule
